// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the rotate-operation arbiter.
package shift_arb_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned AMT_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Operand captured at acceptance, held through EXEC.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amt;
        logic              dir;
        logic              id;
    } op_t;

endpackage

// File: rtl/rotate_core_4bit.sv
// Purely combinational 4-bit circular rotate, left or right by 0-3.
module rotate_core_4bit
    import shift_arb_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    input  logic [AMT_W-1:0]  amt,
    input  logic              dir,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = d;
        if (dir == DIR_LEFT) begin
            case (amt)
                2'd1:    y = {d[2:0], d[3]};
                2'd2:    y = {d[1:0], d[3:2]};
                2'd3:    y = {d[0], d[3:1]};
                default: y = d;
            endcase
        end else begin
            case (amt)
                2'd1:    y = {d[0], d[3:1]};
                2'd2:    y = {d[1:0], d[3:2]};
                2'd3:    y = {d[2:0], d[3]};
                default: y = d;
            endcase
        end
    end

endmodule

// File: rtl/shift_arbiter_4bit.sv
// Two-requester arbiter feeding a shared rotate unit; one operation in flight,
// result held on rsp_* until the consumer takes it.
module shift_arbiter_4bit
    import shift_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [AMT_W-1:0]  req0_amt,
    input  logic              req0_dir,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [AMT_W-1:0]  req1_amt,
    input  logic              req1_dir,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic              ptr;
    op_t               op;
    op_t               op_in;
    logic              grant0;
    logic              grant1;
    logic [DATA_W-1:0] rot_y;

    // Grant decision; gated by rst_n so ready stays low during reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && rst_n) begin
            if (FIXED_PRIO) begin
                grant0 = req0_valid;
                grant1 = req1_valid && !req0_valid;
            end else if (req0_valid && req1_valid) begin
                grant0 = !ptr;
                grant1 = ptr;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != IDLE);

    always_comb begin
        op_in = '{data: req0_data, amt: req0_amt, dir: req0_dir, id: 1'b0};
        if (grant1) begin
            op_in = '{data: req1_data, amt: req1_amt, dir: req1_dir, id: 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant0 || grant1) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    rotate_core_4bit u_rot (
        .d   (op.data),
        .amt (op.amt),
        .dir (op.dir),
        .y   (rot_y)
    );

    // Operand latch, round-robin pointer and response register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op        <= '0;
            ptr       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
        end else begin
            if (grant0 || grant1) begin
                op  <= op_in;
                ptr <= grant0;
            end
            if (state == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_data  <= rot_y;
                rsp_id    <= op.id;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter_4bit.sv
// Directed bench: round-robin instance plus a fixed-priority instance on shared stimulus.
module tb_shift_arbiter_4bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_data, req1_data;
    logic [1:0] req0_amt, req1_amt;
    logic       req0_dir, req1_dir;
    logic       rsp_ready;

    logic       req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [3:0] rsp_data;
    logic       fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_busy;
    logic [3:0] fp_rsp_data;
    logic       fp_r1_seen;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    shift_arbiter_4bit #(.FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_dir(req0_dir),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_dir(req1_dir),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .busy(busy)
    );

    shift_arbiter_4bit #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_dir(req0_dir),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_dir(req1_dir),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(fp_rsp_data),
        .rsp_id(fp_rsp_id), .busy(fp_busy)
    );

    always @(posedge clk) begin
        if (rst_n === 1'b0) fp_r1_seen <= 1'b0;
        else if (fp_req1_ready === 1'b1) fp_r1_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        req0_data  = 4'b1101;
        req0_amt   = 2'b01;
        req0_dir   = 1'b0;
        req1_data  = 4'b0000;
        req1_amt   = 2'b00;
        req1_dir   = 1'b0;
        rsp_ready  = 1'b0;
        #2;
        chk("rst_rsp_valid", 4'(rsp_valid), 4'd0);
        chk("rst_rsp_data", rsp_data, 4'b0000);
        chk("rst_rsp_id", 4'(rsp_id), 4'd0);
        chk("rst_busy", 4'(busy), 4'd0);
        chk("rst_ready0", 4'(req0_ready), 4'd0);
        tick();
        tick();
        #2 rst_n = 1'b1;

        // req0 alone: 1101 rotl 1 -> 1011
        #1;
        chk("t1_ready0", 4'(req0_ready), 4'd1);
        chk("t1_ready1", 4'(req1_ready), 4'd0);
        tick();
        req0_valid = 1'b0;
        chk("t1_exec_ready0", 4'(req0_ready), 4'd0);
        chk("t1_exec_busy", 4'(busy), 4'd1);
        chk("t1_exec_rspv", 4'(rsp_valid), 4'd0);
        tick();
        chk("t1_rsp_valid", 4'(rsp_valid), 4'd1);
        chk("t1_rsp_data", rsp_data, 4'b1011);
        chk("t1_rsp_id", 4'(rsp_id), 4'd0);
        rsp_ready = 1'b1;
        tick();
        chk("t1_done_valid", 4'(rsp_valid), 4'd0);
        chk("t1_done_busy", 4'(busy), 4'd0);
        rsp_ready = 1'b0;

        // 1101 rotr 3 -> 1011, held under backpressure
        req0_amt   = 2'b11;
        req0_dir   = 1'b1;
        req0_valid = 1'b1;
        #1;
        chk("t2_ready0", 4'(req0_ready), 4'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 4'(rsp_valid), 4'd1);
            chk("t2_hold_data", rsp_data, 4'b1011);
            chk("t2_hold_ready0", 4'(req0_ready), 4'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("t2_done_valid", 4'(rsp_valid), 4'd0);
        chk("t2_done_busy", 4'(busy), 4'd0);

        // Fresh reset, both requesters valid, consumer always ready
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        req0_data  = 4'b1101;
        req0_amt   = 2'b10;
        req0_dir   = 1'b0;
        req1_data  = 4'b0001;
        req1_amt   = 2'b01;
        req1_dir   = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("rr_ready0", 4'(req0_ready), (g % 2 == 0) ? 4'd1 : 4'd0);
            chk("rr_ready1", 4'(req1_ready), (g % 2 == 1) ? 4'd1 : 4'd0);
            if (g < 3) begin
                chk("fp_ready0", 4'(fp_req0_ready), 4'd1);
                chk("fp_ready1", 4'(fp_req1_ready), 4'd0);
            end
            tick();
            tick();
            chk("rr_rsp_valid", 4'(rsp_valid), 4'd1);
            chk("rr_rsp_id", 4'(rsp_id), (g % 2 == 1) ? 4'd1 : 4'd0);
            chk("rr_rsp_data", rsp_data, (g % 2 == 0) ? 4'b0111 : 4'b1000);
            if (g < 3) begin
                chk("fp_rsp_id", 4'(fp_rsp_id), 4'd0);
                chk("fp_rsp_data", fp_rsp_data, 4'b0111);
            end
            tick();
        end
        chk("fp_req1_never", 4'(fp_r1_seen), 4'd0);

        // Grant req0 (pointer moves to req1), park in RESP, then reset mid-cycle
        rsp_ready = 1'b0;
        chk("t5_ready0", 4'(req0_ready), 4'd1);
        tick();
        tick();
        chk("t5_rsp_valid", 4'(rsp_valid), 4'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 4'(rsp_valid), 4'd0);
        chk("t5_rst_busy", 4'(busy), 4'd0);
        chk("t5_rst_ready0", 4'(req0_ready), 4'd0);
        chk("t5_rst_ready1", 4'(req1_ready), 4'd0);
        #1 rst_n = 1'b1;
        #1;
        chk("t5_post_ready0", 4'(req0_ready), 4'd1);
        chk("t5_post_ready1", 4'(req1_ready), 4'd0);
        chk("t5_post_valid", 4'(rsp_valid), 4'd0);
        tick();
        chk("t5_exec_valid", 4'(rsp_valid), 4'd0);
        rsp_ready = 1'b1;
        tick();
        chk("t5_rsp_valid2", 4'(rsp_valid), 4'd1);
        chk("t5_rsp_id", 4'(rsp_id), 4'd0);
        chk("t5_rsp_data", rsp_data, 4'b0111);
        tick();

        // amt=0 passes data in both directions; operand edits after grant ignored
        req1_valid = 1'b0;
        req0_data  = 4'b1010;
        req0_amt   = 2'b00;
        req0_dir   = 1'b0;
        #1;
        chk("t6_ready_a", 4'(req0_ready), 4'd1);
        tick();
        req0_data = 4'b1111;
        req0_dir  = 1'b1;
        chk("t6_exec_ready", 4'(req0_ready), 4'd0);
        tick();
        chk("t6_left_data", rsp_data, 4'b1010);
        chk("t6_resp_ready", 4'(req0_ready), 4'd0);
        req0_data = 4'b1010;
        tick();
        chk("t6_ready_b", 4'(req0_ready), 4'd1);
        tick();
        tick();
        chk("t6_right_valid", 4'(rsp_valid), 4'd1);
        chk("t6_right_data", rsp_data, 4'b1010);
        tick();
        chk("t6_ready_c", 4'(req0_ready), 4'd1);
        req0_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
